// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary: forward-select
// encoding and the architectural PC register index.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [3:0] PC_REG   = 4'hF;
    localparam int         NUM_OPND = 2;

endpackage

// File: rtl/decode_exec_reg_fwd.sv
// Operand forwarding slice: address compare against the M and W writers plus
// the 3:1 operand mux. M outranks W; the PC register is never redirected.
module operand_fwd
    import cpu_pipe_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int AMOUNT_REG = 4
) (
    input  logic [AMOUNT_REG-1:0] ra,
    input  logic [SIZE-1:0]       rd,
    input  logic                  regwrite_m,
    input  logic [AMOUNT_REG-1:0] wa3_m,
    input  logic [SIZE-1:0]       aluresult_m,
    input  logic                  regwrite_w,
    input  logic [AMOUNT_REG-1:0] wa3_w,
    input  logic [SIZE-1:0]       result_w,
    output fwd_sel_t              sel,
    output logic [SIZE-1:0]       data
);

    localparam logic [AMOUNT_REG-1:0] PC_ADDR = AMOUNT_REG'(PC_REG);

    logic is_pc;
    logic hit_m;
    logic hit_w;

    assign is_pc = (ra == PC_ADDR);
    assign hit_m = regwrite_m && (wa3_m == ra) && !is_pc;
    assign hit_w = regwrite_w && (wa3_w == ra) && !is_pc;

    always_comb begin
        sel  = FWD_RF;
        data = rd;
        if (hit_m) begin
            sel  = FWD_M;
            data = aluresult_m;
        end else if (hit_w) begin
            sel  = FWD_W;
            data = result_w;
        end
    end

endmodule

// File: rtl/decode_exec_reg.sv
// Decode->Execute pipeline register with D-stage write bypass, E-stage
// forwarding from M/W, and load-use stall/bubble generation.
module decode_exec_reg
    import cpu_pipe_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int AMOUNT_REG = 4,
    parameter int CTRL_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_d,
    input  logic [AMOUNT_REG-1:0] ra1_d,
    input  logic [AMOUNT_REG-1:0] ra2_d,
    input  logic [AMOUNT_REG-1:0] ra3_d,
    input  logic [SIZE-1:0]       rd1_d,
    input  logic [SIZE-1:0]       rd2_d,
    input  logic [SIZE-1:0]       extimm_d,
    input  logic [CTRL_W-1:0]     ctrl_d,
    input  logic                  regwrite_d,
    input  logic                  memtoreg_d,
    input  logic                  hold_e,
    input  logic                  flush_e,
    input  logic                  regwrite_m,
    input  logic [AMOUNT_REG-1:0] wa3_m,
    input  logic [SIZE-1:0]       aluresult_m,
    input  logic                  regwrite_w,
    input  logic [AMOUNT_REG-1:0] wa3_w,
    input  logic [SIZE-1:0]       result_w,
    output logic                  valid_e,
    output logic [SIZE-1:0]       srca_e,
    output logic [SIZE-1:0]       srcb_e,
    output logic [SIZE-1:0]       extimm_e,
    output logic [AMOUNT_REG-1:0] wa3_e,
    output logic [CTRL_W-1:0]     ctrl_e,
    output logic                  regwrite_e,
    output logic                  memtoreg_e,
    output logic [1:0]            fwda_e,
    output logic [1:0]            fwdb_e,
    output logic                  stall_d
);

    localparam logic [AMOUNT_REG-1:0] PC_ADDR = AMOUNT_REG'(PC_REG);

    logic                  valid_e_reg;
    logic                  regwrite_e_reg;
    logic                  memtoreg_e_reg;
    logic [SIZE-1:0]       extimm_e_reg;
    logic [AMOUNT_REG-1:0] wa3_e_reg;
    logic [CTRL_W-1:0]     ctrl_e_reg;

    logic [AMOUNT_REG-1:0] ra_d     [NUM_OPND];
    logic [AMOUNT_REG-1:0] ra_e_reg [NUM_OPND];
    logic [SIZE-1:0]       rd_d     [NUM_OPND];
    logic [SIZE-1:0]       cap_d    [NUM_OPND];
    logic [SIZE-1:0]       rd_e_reg [NUM_OPND];
    logic [SIZE-1:0]       src_e    [NUM_OPND];
    fwd_sel_t              sel_e    [NUM_OPND];
    fwd_sel_t              byp_sel_unused [NUM_OPND];

    logic load_use;
    logic bubble;

    assign ra_d[0] = ra1_d;
    assign ra_d[1] = ra2_d;
    assign rd_d[0] = rd1_d;
    assign rd_d[1] = rd2_d;

    // Per operand: the D-side instance covers the same-edge regfile write
    // (M tied off), the E-side instance picks between M, W and the latched RD.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
            operand_fwd #(
                .SIZE       (SIZE),
                .AMOUNT_REG (AMOUNT_REG)
            ) u_bypass_d (
                .ra          (ra_d[gi]),
                .rd          (rd_d[gi]),
                .regwrite_m  (1'b0),
                .wa3_m       ({AMOUNT_REG{1'b0}}),
                .aluresult_m ({SIZE{1'b0}}),
                .regwrite_w  (regwrite_w),
                .wa3_w       (wa3_w),
                .result_w    (result_w),
                .sel         (byp_sel_unused[gi]),
                .data        (cap_d[gi])
            );

            operand_fwd #(
                .SIZE       (SIZE),
                .AMOUNT_REG (AMOUNT_REG)
            ) u_fwd_e (
                .ra          (ra_e_reg[gi]),
                .rd          (rd_e_reg[gi]),
                .regwrite_m  (regwrite_m),
                .wa3_m       (wa3_m),
                .aluresult_m (aluresult_m),
                .regwrite_w  (regwrite_w),
                .wa3_w       (wa3_w),
                .result_w    (result_w),
                .sel         (sel_e[gi]),
                .data        (src_e[gi])
            );
        end
    endgenerate

    assign valid_e    = valid_e_reg;
    assign regwrite_e = valid_e_reg & regwrite_e_reg;
    assign memtoreg_e = valid_e_reg & memtoreg_e_reg;
    assign extimm_e   = extimm_e_reg;
    assign wa3_e      = wa3_e_reg;
    assign ctrl_e     = ctrl_e_reg;
    assign srca_e     = src_e[0];
    assign srcb_e     = src_e[1];
    assign fwda_e     = sel_e[0];
    assign fwdb_e     = sel_e[1];

    assign load_use = memtoreg_e && regwrite_e && (wa3_e_reg != PC_ADDR) && valid_d &&
                      ((wa3_e_reg == ra1_d) || (wa3_e_reg == ra2_d));
    assign stall_d  = load_use | hold_e;

    // Flush beats hold; hold beats the load-use bubble.
    assign bubble = flush_e || (!hold_e && load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_reg    <= 1'b0;
            regwrite_e_reg <= 1'b0;
            memtoreg_e_reg <= 1'b0;
            extimm_e_reg   <= '0;
            wa3_e_reg      <= '0;
            ctrl_e_reg     <= '0;
            for (int i = 0; i < NUM_OPND; i++) begin
                ra_e_reg[i] <= '0;
                rd_e_reg[i] <= '0;
            end
        end else if (bubble) begin
            valid_e_reg    <= 1'b0;
            regwrite_e_reg <= 1'b0;
            memtoreg_e_reg <= 1'b0;
        end else if (!hold_e) begin
            valid_e_reg    <= valid_d;
            regwrite_e_reg <= regwrite_d;
            memtoreg_e_reg <= memtoreg_d;
            extimm_e_reg   <= extimm_d;
            wa3_e_reg      <= ra3_d;
            ctrl_e_reg     <= ctrl_d;
            for (int i = 0; i < NUM_OPND; i++) begin
                ra_e_reg[i] <= ra_d[i];
                rd_e_reg[i] <= cap_d[i];
            end
        end
    end

endmodule

// File: tb/tb_decode_exec_reg.sv
// Bench for decode_exec_reg: a behavioural E-slot model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_decode_exec_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_d;
    logic [3:0]  ra1_d, ra2_d, ra3_d;
    logic [31:0] rd1_d, rd2_d, extimm_d;
    logic [11:0] ctrl_d;
    logic        regwrite_d, memtoreg_d, hold_e, flush_e;
    logic        regwrite_m, regwrite_w;
    logic [3:0]  wa3_m, wa3_w;
    logic [31:0] aluresult_m, result_w;
    logic        valid_e, regwrite_e, memtoreg_e, stall_d;
    logic [31:0] srca_e, srcb_e, extimm_e;
    logic [3:0]  wa3_e;
    logic [11:0] ctrl_e;
    logic [1:0]  fwda_e, fwdb_e;

    int checks = 0;
    int errors = 0;

    decode_exec_reg dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .ra3_d(ra3_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .extimm_d(extimm_d), .ctrl_d(ctrl_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
        .hold_e(hold_e), .flush_e(flush_e),
        .regwrite_m(regwrite_m), .wa3_m(wa3_m), .aluresult_m(aluresult_m),
        .regwrite_w(regwrite_w), .wa3_w(wa3_w), .result_w(result_w),
        .valid_e(valid_e), .srca_e(srca_e), .srcb_e(srcb_e), .extimm_e(extimm_e),
        .wa3_e(wa3_e), .ctrl_e(ctrl_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .fwda_e(fwda_e), .fwdb_e(fwdb_e), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    // Model of what sits in the E slot, in instruction terms.
    typedef struct packed {
        logic        valid;
        logic [3:0]  ra1, ra2, wa3;
        logic [31:0] rd1, rd2, imm;
        logic [11:0] ctrl;
        logic        rw, mtr;
    } slot_t;

    slot_t m = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Register value the instruction sees when the regfile is being written this cycle.
    function automatic logic [31:0] reg_value(input logic [3:0] ra, input logic [31:0] rd);
        if (regwrite_w && wa3_w == ra && ra != 4'd15) return result_w;
        return rd;
    endfunction

    function automatic logic [33:0] operand(input logic [3:0] ra, input logic [31:0] rd);
        if (ra == 4'd15)                   return {2'b00, rd};
        if (regwrite_m && wa3_m == ra)     return {2'b10, aluresult_m};
        if (regwrite_w && wa3_w == ra)     return {2'b01, result_w};
        return {2'b00, rd};
    endfunction

    function automatic logic load_use_now();
        return m.valid && m.mtr && m.rw && m.wa3 != 4'd15 && valid_d &&
               (m.wa3 == ra1_d || m.wa3 == ra2_d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '0;
        end else if (flush_e || (!hold_e && load_use_now())) begin
            m.valid = 1'b0; m.rw = 1'b0; m.mtr = 1'b0;
        end else if (!hold_e) begin
            m.valid = valid_d;   m.rw = regwrite_d; m.mtr = memtoreg_d;
            m.ra1 = ra1_d;       m.ra2 = ra2_d;     m.wa3 = ra3_d;
            m.rd1 = reg_value(ra1_d, rd1_d);
            m.rd2 = reg_value(ra2_d, rd2_d);
            m.imm = extimm_d;    m.ctrl = ctrl_d;
        end
    end

    always @(negedge clk) begin
        logic [33:0] oa, ob;
        oa = operand(m.ra1, m.rd1);
        ob = operand(m.ra2, m.rd2);
        chk("valid_e",    {31'b0, valid_e},    {31'b0, m.valid});
        chk("srca_e",     srca_e,              oa[31:0]);
        chk("srcb_e",     srcb_e,              ob[31:0]);
        chk("fwda_e",     {30'b0, fwda_e},     {30'b0, oa[33:32]});
        chk("fwdb_e",     {30'b0, fwdb_e},     {30'b0, ob[33:32]});
        chk("extimm_e",   extimm_e,            m.imm);
        chk("wa3_e",      {28'b0, wa3_e},      {28'b0, m.wa3});
        chk("ctrl_e",     {20'b0, ctrl_e},     {20'b0, m.ctrl});
        chk("regwrite_e", {31'b0, regwrite_e}, {31'b0, m.valid & m.rw});
        chk("memtoreg_e", {31'b0, memtoreg_e}, {31'b0, m.valid & m.mtr});
        chk("stall_d",    {31'b0, stall_d},    {31'b0, load_use_now() | hold_e});
    end

    task automatic drive_d(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                           input logic [3:0] a3, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [11:0] c,
                           input logic rw, input logic mtr);
        valid_d = v; ra1_d = a1; ra2_d = a2; ra3_d = a3; rd1_d = d1; rd2_d = d2;
        extimm_d = imm; ctrl_d = c; regwrite_d = rw; memtoreg_d = mtr;
    endtask

    task automatic idle_d();
        drive_d(1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 12'd0, 1'b0, 1'b0);
    endtask

    task automatic mw(input logic rwm, input logic [3:0] wm, input logic [31:0] am,
                      input logic rww, input logic [3:0] ww, input logic [31:0] rs);
        regwrite_m = rwm; wa3_m = wm; aluresult_m = am;
        regwrite_w = rww; wa3_w = ww; result_w = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hold_e = 1'b0; flush_e = 1'b0;
        idle_d();
        mw(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        $display("[%0t] reset with toggling D inputs", $time);
        for (int i = 0; i < 4; i++) begin
            drive_d(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom, $urandom,
                    $urandom, 12'($urandom), 1'b1, 1'b1);
            at_neg();
            chk("rst_valid_e", {31'b0, valid_e}, 32'd0);
            chk("rst_regwrite_e", {31'b0, regwrite_e}, 32'd0);
            chk("rst_srca_e", srca_e, 32'd0);
            chk("rst_stall_d", {31'b0, stall_d}, 32'd0);
        end
        rst_n = 1'b1;
        idle_d();
        step();

        $display("[%0t] M forward to SUB r2,r1", $time);
        drive_d(1'b1, 4'd1, 4'd5, 4'd2, 32'h5, 32'h7, 32'h100, 12'h0A5, 1'b1, 1'b0);
        step();
        idle_d();
        mw(1'b1, 4'd1, 32'h10, 1'b0, 4'd0, 32'd0);
        at_neg();
        chk("t2_fwda", {30'b0, fwda_e}, 32'd2);
        chk("t2_srca", srca_e, 32'h10);
        chk("t2_srcb", srcb_e, 32'h7);

        $display("[%0t] M over W priority on r3", $time);
        mw(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_d(1'b1, 4'd4, 4'd3, 4'd8, 32'h44, 32'h33, 32'h0, 12'h0, 1'b1, 1'b0);
        step();
        idle_d();
        mw(1'b1, 4'd3, 32'hAA, 1'b1, 4'd3, 32'hBB);
        at_neg();
        chk("t3_srcb_m", srcb_e, 32'hAA);
        chk("t3_fwdb_m", {30'b0, fwdb_e}, 32'd2);
        mw(1'b0, 4'd3, 32'hAA, 1'b1, 4'd3, 32'hBB);
        #2;
        chk("t3_srcb_w", srcb_e, 32'hBB);
        chk("t3_fwdb_w", {30'b0, fwdb_e}, 32'd1);

        $display("[%0t] load-use on r4", $time);
        mw(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_d(1'b1, 4'd6, 4'd7, 4'd4, 32'h60, 32'h70, 32'h0, 12'h0, 1'b1, 1'b1);
        step();
        drive_d(1'b1, 4'd4, 4'd8, 4'd5, 32'hDEAD, 32'h80, 32'h4, 12'h0, 1'b1, 1'b0);
        at_neg();
        chk("t4_stall", {31'b0, stall_d}, 32'd1);
        step();
        mw(1'b1, 4'd4, 32'h1000, 1'b0, 4'd0, 32'd0);
        at_neg();
        chk("t4_bubble_valid", {31'b0, valid_e}, 32'd0);
        chk("t4_bubble_stall", {31'b0, stall_d}, 32'd0);
        step();
        idle_d();
        mw(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h4444);
        at_neg();
        chk("t4_valid", {31'b0, valid_e}, 32'd1);
        chk("t4_srca", srca_e, 32'h4444);
        chk("t4_fwda", {30'b0, fwda_e}, 32'd1);
        chk("t4_srcb", srcb_e, 32'h80);

        $display("[%0t] D-stage write bypass r2", $time);
        drive_d(1'b1, 4'd2, 4'd9, 4'd10, 32'h0, 32'h99, 32'h0, 12'h0, 1'b1, 1'b0);
        mw(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h77);
        step();
        idle_d();
        mw(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        at_neg();
        chk("t5_srca", srca_e, 32'h77);
        chk("t5_fwda", {30'b0, fwda_e}, 32'd0);

        $display("[%0t] R15 never forwarded", $time);
        drive_d(1'b1, 4'd15, 4'd1, 4'd3, 32'h1234, 32'h11, 32'h0, 12'h0, 1'b1, 1'b0);
        mw(1'b1, 4'd15, 32'hBAD, 1'b1, 4'd15, 32'hBEEF);
        step();
        idle_d();
        at_neg();
        chk("t6_srca", srca_e, 32'h1234);
        chk("t6_fwda", {30'b0, fwda_e}, 32'd0);

        $display("[%0t] flush with load-use, then hold", $time);
        mw(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_d(1'b1, 4'd1, 4'd2, 4'd6, 32'h1, 32'h2, 32'h0, 12'h0, 1'b1, 1'b1);
        step();
        drive_d(1'b1, 4'd6, 4'd3, 4'd7, 32'h66, 32'h33, 32'h0, 12'h0, 1'b1, 1'b0);
        flush_e = 1'b1;
        at_neg();
        chk("t7_flush_stall", {31'b0, stall_d}, 32'd1);
        step();
        flush_e = 1'b0;
        at_neg();
        chk("t7_flush_valid", {31'b0, valid_e}, 32'd0);
        drive_d(1'b1, 4'd3, 4'd4, 4'd7, 32'h3, 32'h4, 32'h55, 12'h123, 1'b1, 1'b0);
        step();
        hold_e = 1'b1;
        drive_d(1'b1, 4'd8, 4'd9, 4'd11, 32'h88, 32'h99, 32'h77, 12'hFFF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t7_hold_srca", srca_e, 32'h3);
            chk("t7_hold_imm", extimm_e, 32'h55);
            chk("t7_hold_ctrl", {20'b0, ctrl_e}, 32'h123);
            chk("t7_hold_valid", {31'b0, valid_e}, 32'd1);
            chk("t7_hold_stall", {31'b0, stall_d}, 32'd1);
            step();
        end
        hold_e = 1'b0;
        step();
        idle_d();
        at_neg();
        chk("t7_rel_imm", extimm_e, 32'h77);
        chk("t7_rel_ctrl", {20'b0, ctrl_e}, 32'hFFF);
        chk("t7_rel_srca", srca_e, 32'h88);

        $display("[%0t] flush together with hold", $time);
        hold_e = 1'b1; flush_e = 1'b1;
        at_neg();
        chk("t8_stall", {31'b0, stall_d}, 32'd1);
        step();
        hold_e = 1'b0; flush_e = 1'b0;
        at_neg();
        chk("t8_valid", {31'b0, valid_e}, 32'd0);
        chk("t8_imm_kept", extimm_e, 32'h77);

        $display("[%0t] reset during load-use stall", $time);
        drive_d(1'b1, 4'd1, 4'd2, 4'd5, 32'h1, 32'h2, 32'h0, 12'h0, 1'b1, 1'b1);
        step();
        drive_d(1'b1, 4'd5, 4'd0, 4'd6, 32'h5, 32'h0, 32'h0, 12'h0, 1'b1, 1'b0);
        at_neg();
        chk("t9_stall_pre", {31'b0, stall_d}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t9_valid_rst", {31'b0, valid_e}, 32'd0);
        chk("t9_stall_rst", {31'b0, stall_d}, 32'd0);
        step();
        rst_n = 1'b1;
        idle_d();
        step();
        at_neg();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
